modn_cascade_counter: RTL and testbench



---
 rtl/modn_counter_pkg.sv | 16 +
 rtl/modn_digit.sv | 47 ++++
 rtl/modn_cascade_counter.sv | 90 +++++++++
 tb/tb_modn_cascade_counter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/modn_counter_pkg.sv
// Shared limits and helpers for the cascaded modulo counter.
// Pure elaboration-time content; no logic, no latency.
package modn_counter_pkg;

  localparam int MAX_STAGES = 8;
  localparam int MAX_WIDTH  = 8;

  function automatic int mod_of(input logic [MAX_STAGES*8-1:0] mods, input int i);
    return int'(mods[i*8 +: 8]);
  endfunction

  function automatic bit mod_legal(input int mod, input int width);
    return (mod >= 2) && (mod <= (1 << width));
  endfunction

endpackage

// File: rtl/modn_digit.sv
// One modulo-MOD digit with up/down step, parallel load and range check.
// Registered value, 1-cycle latency; carry/at_* flags are combinational from state.
module modn_digit import modn_counter_pkg::*; #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             at_max,
  output logic             at_zero,
  output logic             carry,
  output logic             illegal
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MOD_V = (WIDTH+1)'(MOD);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    at_max  = (q_q == MAX_V);
    at_zero = (q_q == '0);
    carry   = step && (up ? at_max : at_zero);
    illegal = ({1'b0, load_val} >= MOD_V);
    q_d     = q_q;
    if (load) begin
      q_d = illegal ? '0 : load_val;
    end else if (step) begin
      if (up) q_d = at_max  ? '0    : q_q + 1'b1;
      else    q_d = at_zero ? MAX_V : q_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/modn_cascade_counter.sv
// Multi-digit cascaded modulo counter: up/down, load with legality check, wrap or saturate.
// All outputs registered, 1-cycle latency; no flow control, one step per enabled cycle.
module modn_cascade_counter import modn_counter_pkg::*; #(
  parameter int                  STAGES = 2,
  parameter int                  WIDTH  = 4,
  parameter logic [STAGES*8-1:0] MODS   = {8'd6, 8'd10}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up,
  input  logic                    sat,
  input  logic                    load,
  input  logic [STAGES*WIDTH-1:0] load_val,
  output logic [STAGES*WIDTH-1:0] count,
  output logic                    tc,
  output logic                    load_err
);

  localparam logic [MAX_STAGES*8-1:0] MODS_EXT = (MAX_STAGES*8)'(MODS);

  if (STAGES < 1 || STAGES > MAX_STAGES || WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_cfg
    $error("modn_cascade_counter: STAGES/WIDTH out of range");
  end

  logic [STAGES-1:0] step;
  logic [STAGES-1:0] at_max;
  logic [STAGES-1:0] at_zero;
  logic [STAGES-1:0] carry;
  logic [STAGES-1:0] illegal;

  logic step0;
  logic terminal;
  logic blocked;
  logic tc_q, tc_d;
  logic load_err_q, load_err_d;

  // Each higher digit steps only when every digit below it rolls over.
  if (STAGES > 1) begin : g_chain
    assign step = {carry[STAGES-2:0], step0};
  end else begin : g_single
    assign step = step0;
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_digit
    if (!mod_legal(mod_of(MODS_EXT, i), WIDTH)) begin : g_bad_mod
      $error("modn_cascade_counter: MODS digit out of range 2..2^WIDTH");
    end

    modn_digit #(
      .WIDTH (WIDTH),
      .MOD   (mod_of(MODS_EXT, i))
    ) u_digit (
      .clk      (clk),
      .rst      (rst),
      .step     (step[i]),
      .up       (up),
      .load     (load),
      .load_val (load_val[i*WIDTH +: WIDTH]),
      .q        (count[i*WIDTH +: WIDTH]),
      .at_max   (at_max[i]),
      .at_zero  (at_zero[i]),
      .carry    (carry[i]),
      .illegal  (illegal[i])
    );
  end

  // A carry out of the top digit is exactly a wrap from the terminal value.
  always_comb begin
    terminal   = up ? (&at_max) : (&at_zero);
    blocked    = sat && terminal;
    step0      = en && !load && !blocked;
    tc_d       = carry[STAGES-1] || (en && !load && blocked);
    load_err_d = load && (|illegal);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      tc_q       <= tc_d;
      load_err_q <= load_err_d;
    end
  end

  assign tc       = tc_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_modn_cascade_counter.sv
// Directed bench for modn_cascade_counter, default 2-digit mod {6,10} configuration.
// count is printed in hex so it reads as tens:units.
module tb_modn_cascade_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up;
  logic       sat;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       tc;
  logic       load_err;

  int tests = 0;
  int fails = 0;
  bit range_on = 1'b0;

  always #5 clk = ~clk;

  modn_cascade_counter #(
    .STAGES (2),
    .WIDTH  (4),
    .MODS   (16'h060A)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .sat      (sat),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc),
    .load_err (load_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [7:0] c, input logic t, input logic e);
    check({tag, "_count"}, 32'(count), 32'(c));
    check({tag, "_tc"}, 32'(tc), 32'(t));
    check({tag, "_lerr"}, 32'(load_err), 32'(e));
  endtask

  // Digit range invariant, sampled mid-cycle whenever reset is low.
  always @(negedge clk) begin
    if (range_on && !rst) begin
      check("tens_range", 32'(count[7:4] < 4'd6), 32'd1);
      check("units_range", 32'(count[3:0] < 4'd10), 32'd1);
    end
  end

  initial begin
    logic [7:0] exp_c;
    int v;
    rst = 1'b1; en = 1'b1; up = 1'b1; sat = 1'b0; load = 1'b0; load_val = 8'h00;

    tick();
    tick();
    expect_state("reset", 8'h00, 1'b0, 1'b0);
    range_on = 1'b1;

    // Up wrap across all 60 states.
    rst = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      v = k % 60;
      exp_c = {4'(v / 10), 4'(v % 10)};
      check("upwrap_count", 32'(count), 32'(exp_c));
      check("upwrap_tc", 32'(tc), 32'(k == 60));
    end

    // Down wrap from 00.
    load = 1'b1; load_val = 8'h00; up = 1'b0;
    tick();
    expect_state("dn_load", 8'h00, 1'b0, 1'b0);
    load = 1'b0;
    tick();
    expect_state("dn_wrap", 8'h59, 1'b1, 1'b0);
    tick();
    expect_state("dn_next", 8'h58, 1'b0, 1'b0);

    // Saturate up at 59.
    load = 1'b1; load_val = 8'h58; sat = 1'b1; up = 1'b1;
    tick();
    expect_state("sat_load", 8'h58, 1'b0, 1'b0);
    load = 1'b0;
    tick(); expect_state("sat1", 8'h59, 1'b0, 1'b0);
    tick(); expect_state("sat2", 8'h59, 1'b1, 1'b0);
    tick(); expect_state("sat3", 8'h59, 1'b1, 1'b0);
    tick(); expect_state("sat4", 8'h59, 1'b1, 1'b0);
    en = 1'b0;
    tick(); expect_state("sat_noen", 8'h59, 1'b0, 1'b0);

    // Illegal tens digit; load beats en.
    en = 1'b1; load = 1'b1; load_val = 8'h73;
    tick(); expect_state("ill_tens", 8'h03, 1'b0, 1'b1);
    load = 1'b0; en = 1'b0;
    tick(); expect_state("ill_clear", 8'h03, 1'b0, 1'b0);

    // Direction change takes effect on the very next step.
    en = 1'b1; sat = 1'b0; up = 1'b0;
    tick(); expect_state("dir_dn", 8'h02, 1'b0, 1'b0);
    up = 1'b1;
    tick(); expect_state("dir_up", 8'h03, 1'b0, 1'b0);

    // Illegal units digits (12 and exactly 10).
    load = 1'b1; load_val = 8'h5C;
    tick(); expect_state("ill_unit12", 8'h50, 1'b0, 1'b1);
    load_val = 8'h5A;
    tick(); expect_state("ill_unit10", 8'h50, 1'b0, 1'b1);
    load_val = 8'h60;
    tick(); expect_state("ill_tens6", 8'h00, 1'b0, 1'b1);

    // Saturate down at 00.
    load_val = 8'h00; up = 1'b0; sat = 1'b1;
    tick(); expect_state("satdn_load", 8'h00, 1'b0, 1'b0);
    load = 1'b0;
    tick(); expect_state("satdn_hold", 8'h00, 1'b1, 1'b0);

    // Mid-operation reset overrides load and en.
    sat = 1'b0; up = 1'b1; load = 1'b1; load_val = 8'h37;
    tick(); expect_state("mid_load", 8'h37, 1'b0, 1'b0);
    load_val = 8'h7F; rst = 1'b1;
    tick(); expect_state("mid_rst", 8'h00, 1'b0, 1'b0);
    rst = 1'b0; load = 1'b0;
    tick(); expect_state("mid_resume", 8'h01, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
